disp_src_sched: RTL and testbench

//  Display-source scheduler and time-set controller for the 8-digit HH:MM:SS scanner.

---
 rtl/disp_src_sched_pkg.sv | 30 +++
 rtl/disp_src_sched_field_wrap_inc.sv | 14 +
 rtl/disp_src_sched.sv | 207 ++++++++++++++++++++
 tb/tb_disp_src_sched.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/disp_src_sched_pkg.sv
// Shared definitions for the display-source scheduler: FSM state encoding,
// field codes, field limits and {HH,MM,SS} slice positions.
package disp_src_sched_pkg;

    typedef enum logic [2:0] {
        ST_SHOW_TIME  = 3'd0,
        ST_SHOW_ALARM = 3'd1,
        ST_SHOW_SW    = 3'd2,
        ST_SET_H      = 3'd3,
        ST_SET_M      = 3'd4,
        ST_SET_S      = 3'd5
    } state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HH   = 2'd1;
    localparam logic [1:0] FLD_MM   = 2'd2;
    localparam logic [1:0] FLD_SS   = 2'd3;

    localparam logic [7:0] HH_MAX = 8'd23;
    localparam logic [7:0] MS_MAX = 8'd59;

    localparam int HH_LSB = 16;
    localparam int MM_LSB = 8;
    localparam int SS_LSB = 0;

    function automatic logic is_set(input state_t s);
        return (s == ST_SET_H) || (s == ST_SET_M) || (s == ST_SET_S);
    endfunction

endpackage

// File: rtl/disp_src_sched_field_wrap_inc.sv
// Wrapping increment of one 8-bit time field.
//  val  in  8  current field value (may be out of range)
//  max  in  8  highest legal value (23 for hours, 59 for minutes/seconds)
//  nxt  out 8  val+1, or 0 once val has reached or passed max
module field_wrap_inc (
    input  logic [7:0] val,
    input  logic [7:0] max,
    output logic [7:0] nxt
);

    // ">=" rather than "==" so a field that arrived out of range wraps to 0.
    assign nxt = (val >= max) ? 8'd0 : val + 8'd1;

endmodule

// File: rtl/disp_src_sched.sv
// Display-source scheduler and time-set controller for the HH:MM:SS scanner.
// Chooses which {HH,MM,SS} word drives the scanner, runs the button-driven
// set sequence and issues a single commit strobe to the clock or alarm.
//  clk1000    in   1 kHz clock
//  rst        in   async active-low reset
//  time_bus   in   live clock word
//  alarm_bus  in   stored alarm word
//  sw_bus     in   stopwatch word
//  alarm_ring in   alarm sounding (level)
//  btn_mode   in   pulse: next view / abort edit
//  btn_sel    in   pulse: enter edit / next field / commit
//  btn_inc    in   pulse: increment edited field
//  bus        out  registered word to scanner
//  set_load   out  one-cycle commit strobe
//  set_tgt    out  0 clock, 1 alarm
//  set_val    out  committed word
//  field      out  0 none, 1 HH, 2 MM, 3 SS
//  blink      out  edit blink indicator
module disp_src_sched
    import disp_src_sched_pkg::*;
#(
    parameter int IDLE_MS  = 10000,
    parameter int BLINK_MS = 250
) (
    input  logic        clk1000,
    input  logic        rst,
    input  logic [23:0] time_bus,
    input  logic [23:0] alarm_bus,
    input  logic [23:0] sw_bus,
    input  logic        alarm_ring,
    input  logic        btn_mode,
    input  logic        btn_sel,
    input  logic        btn_inc,
    output logic [23:0] bus,
    output logic        set_load,
    output logic        set_tgt,
    output logic [23:0] set_val,
    output logic [1:0]  field,
    output logic        blink
);

    localparam int IW = $clog2(IDLE_MS);
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    state_t        state, state_nx;
    logic          origin;       // 0 edit came from clock, 1 from alarm
    logic [23:0]   edit;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;

    logic          any_btn, timeout;
    logic          cap_time, cap_alarm, commit, do_inc;
    logic [7:0]    inc_val, inc_max, inc_nxt;
    state_t        origin_view;

    assign any_btn     = btn_mode | btn_sel | btn_inc;
    // A pulse in the same cycle clears the counter, so it outranks the timeout.
    assign timeout     = (idle_cnt == IDLE_LAST) && !any_btn;
    assign origin_view = origin ? ST_SHOW_ALARM : ST_SHOW_TIME;

    always_ff @(posedge clk1000 or negedge rst) begin
        if (!rst) state <= ST_SHOW_TIME;
        else      state <= state_nx;
    end

    // Button priority mode > sel > inc falls out of the if/else ordering.
    always_comb begin
        state_nx  = state;
        cap_time  = 1'b0;
        cap_alarm = 1'b0;
        commit    = 1'b0;
        do_inc    = 1'b0;
        case (state)
            ST_SHOW_TIME: begin
                if (btn_mode) state_nx = ST_SHOW_ALARM;
                else if (btn_sel) begin
                    state_nx = ST_SET_H;
                    cap_time = 1'b1;
                end
            end
            ST_SHOW_ALARM: begin
                if (btn_mode) state_nx = ST_SHOW_SW;
                else if (btn_sel) begin
                    state_nx  = ST_SET_H;
                    cap_alarm = 1'b1;
                end
                else if (timeout) state_nx = ST_SHOW_TIME;
            end
            ST_SHOW_SW: begin
                if (btn_mode || timeout) state_nx = ST_SHOW_TIME;
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (btn_mode) state_nx = origin_view;
                else if (btn_sel) begin
                    if (state == ST_SET_H)      state_nx = ST_SET_M;
                    else if (state == ST_SET_M) state_nx = ST_SET_S;
                    else begin
                        state_nx = origin_view;
                        commit   = 1'b1;
                    end
                end
                else if (btn_inc) do_inc = 1'b1;
                else if (timeout) state_nx = origin_view;
            end
            default: state_nx = ST_SHOW_TIME;
        endcase
    end

    // Single shared incrementer, steered to the field under edit.
    always_comb begin
        inc_val = edit[SS_LSB +: 8];
        inc_max = MS_MAX;
        case (state)
            ST_SET_H: begin
                inc_val = edit[HH_LSB +: 8];
                inc_max = HH_MAX;
            end
            ST_SET_M: inc_val = edit[MM_LSB +: 8];
            default:  inc_val = edit[SS_LSB +: 8];
        endcase
    end

    field_wrap_inc u_inc (
        .val (inc_val),
        .max (inc_max),
        .nxt (inc_nxt)
    );

    always_ff @(posedge clk1000 or negedge rst) begin
        if (!rst) begin
            edit     <= '0;
            origin   <= 1'b0;
            set_tgt  <= 1'b0;
            set_load <= 1'b0;
            set_val  <= '0;
        end else begin
            set_load <= commit;
            if (commit) set_val <= edit;
            if (cap_time) begin
                edit    <= time_bus;
                origin  <= 1'b0;
                set_tgt <= 1'b0;
            end else if (cap_alarm) begin
                edit    <= alarm_bus;
                origin  <= 1'b1;
                set_tgt <= 1'b1;
            end else if (do_inc) begin
                case (state)
                    ST_SET_H: edit[HH_LSB +: 8] <= inc_nxt;
                    ST_SET_M: edit[MM_LSB +: 8] <= inc_nxt;
                    default:  edit[SS_LSB +: 8] <= inc_nxt;
                endcase
            end
        end
    end

    // Idle counter saturates at IDLE_LAST; any pulse or state change restarts it.
    always_ff @(posedge clk1000 or negedge rst) begin
        if (!rst)                               idle_cnt <= '0;
        else if (any_btn || state_nx != state)  idle_cnt <= '0;
        else if (idle_cnt != IDLE_LAST)         idle_cnt <= idle_cnt + 1'b1;
    end

    // Blink runs only while both the current and next state are edit states,
    // so it restarts on entry and never shows 1 on the cycle after leaving.
    always_ff @(posedge clk1000 or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (!is_set(state) || !is_set(state_nx)) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Source select is registered off the current state; the ring override
    // applies only to the home view, never to an edit in progress.
    always_ff @(posedge clk1000 or negedge rst) begin
        if (!rst) bus <= '0;
        else begin
            case (state)
                ST_SHOW_TIME:  bus <= alarm_ring ? alarm_bus : time_bus;
                ST_SHOW_ALARM: bus <= alarm_bus;
                ST_SHOW_SW:    bus <= sw_bus;
                default:       bus <= edit;
            endcase
        end
    end

    always_comb begin
        field = FLD_NONE;
        case (state)
            ST_SET_H: field = FLD_HH;
            ST_SET_M: field = FLD_MM;
            ST_SET_S: field = FLD_SS;
            default:  field = FLD_NONE;
        endcase
    end

endmodule

// File: tb/tb_disp_src_sched.sv
module tb_disp_src_sched;

    localparam int IDLE_MS  = 20;
    localparam int BLINK_MS = 4;

    logic        clk1000 = 1'b0;
    logic        rst;
    logic [23:0] time_bus, alarm_bus, sw_bus;
    logic        alarm_ring, btn_mode, btn_sel, btn_inc;
    logic [23:0] bus, set_val;
    logic        set_load, set_tgt, blink;
    logic [1:0]  field;

    int n_chk = 0;
    int n_err = 0;
    int loads = 0;
    int loads0;

    disp_src_sched #(.IDLE_MS(IDLE_MS), .BLINK_MS(BLINK_MS)) dut (
        .clk1000    (clk1000),
        .rst        (rst),
        .time_bus   (time_bus),
        .alarm_bus  (alarm_bus),
        .sw_bus     (sw_bus),
        .alarm_ring (alarm_ring),
        .btn_mode   (btn_mode),
        .btn_sel    (btn_sel),
        .btn_inc    (btn_inc),
        .bus        (bus),
        .set_load   (set_load),
        .set_tgt    (set_tgt),
        .set_val    (set_val),
        .field      (field),
        .blink      (blink)
    );

    always #5 clk1000 = ~clk1000;

    // Each negedge sees one registered cycle, so this counts load strobes.
    always @(negedge clk1000) if (set_load === 1'b1) loads++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge clk1000);
    endtask

    task automatic pulse(input logic m, input logic s, input logic i);
        @(negedge clk1000);
        btn_mode = m; btn_sel = s; btn_inc = i;
        @(negedge clk1000);
        btn_mode = 0; btn_sel = 0; btn_inc = 0;
    endtask

    initial begin
        rst = 0; alarm_ring = 0; btn_mode = 0; btn_sel = 0; btn_inc = 0;
        time_bus = 24'h0C1E2D; alarm_bus = 24'h061E00; sw_bus = 24'h000205;
        cyc(3);
        chk("rst_bus", bus, 0);
        chk("rst_field", field, 0);
        // 1: reset release
        rst = 1;
        cyc(1);
        chk("t1_bus", bus, 24'h0C1E2D);
        chk("t1_load", set_load, 0);
        chk("t1_field", field, 0);

        // 2: view cycle and idle fallback from stopwatch
        pulse(1, 0, 0); cyc(1); chk("t2_alarm", bus, 24'h061E00);
        pulse(1, 0, 0); cyc(1); chk("t2_sw", bus, 24'h000205);
        pulse(1, 0, 0); cyc(1); chk("t2_time", bus, 24'h0C1E2D);
        pulse(1, 0, 0); pulse(1, 0, 0);
        cyc(IDLE_MS - 5); chk("t2_sw_hold", bus, 24'h000205);
        cyc(10);          chk("t2_idle_home", bus, 24'h0C1E2D);

        // 3: full wrap and commit to clock
        time_bus = 24'h173B3B;
        loads0 = loads;
        pulse(0, 1, 0); chk("t3_fld_h", field, 1);
        pulse(0, 0, 1); cyc(1); chk("t3_hh_wrap", bus, 24'h003B3B);
        pulse(0, 1, 0); chk("t3_fld_m", field, 2);
        pulse(0, 0, 1);
        pulse(0, 1, 0); chk("t3_fld_s", field, 3);
        pulse(0, 0, 1); cyc(1); chk("t3_ss_wrap", bus, 24'h000000);
        time_bus = 24'h010203;
        pulse(0, 1, 0);
        chk("t3_load_now", set_load, 1);
        cyc(2);
        chk("t3_loads", loads - loads0, 1);
        chk("t3_tgt", set_tgt, 0);
        chk("t3_val", set_val, 24'h000000);
        chk("t3_home", bus, 24'h010203);
        chk("t3_fld0", field, 0);

        // 4: alarm edit then abort
        loads0 = loads;
        pulse(1, 0, 0);
        pulse(0, 1, 0); chk("t4_tgt", set_tgt, 1);
        pulse(0, 0, 1); pulse(0, 0, 1); cyc(1);
        chk("t4_edit", bus, 24'h081E00);
        pulse(1, 0, 0); cyc(1);
        chk("t4_bus", bus, 24'h061E00);
        chk("t4_fld0", field, 0);
        chk("t4_noload", loads - loads0, 0);
        pulse(1, 0, 0); pulse(1, 0, 0); cyc(1);
        chk("t4_back", bus, 24'h010203);

        // 5: out-of-range pass-through/wrap, coincident abort, idle abort in SET_S
        time_bus = 24'h283C3C;
        cyc(1); chk("t5_oor_pass", bus, 24'h283C3C);
        loads0 = loads;
        pulse(0, 1, 0); pulse(0, 0, 1); cyc(1);
        chk("t5_oor_wrap", bus, 24'h003C3C);
        pulse(0, 1, 0); chk("t5_fld_m", field, 2);
        pulse(1, 1, 0); chk("t5_abort_fld", field, 0);
        cyc(1); chk("t5_abort_bus", bus, 24'h283C3C);
        pulse(0, 1, 0); pulse(0, 1, 0); pulse(0, 1, 0);
        chk("t5_fld_s", field, 3);
        cyc(IDLE_MS - 5); chk("t5_still_s", field, 3);
        cyc(10);          chk("t5_idle_abort", field, 0);
        chk("t5_noload", loads - loads0, 0);

        // 6: alarm ring override, ring ignored while editing, blink, reset mid-edit
        time_bus = 24'h0C1E2D;
        alarm_ring = 1;
        cyc(2); chk("t6_ring_home", bus, 24'h061E00);
        loads0 = loads;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("t6_blink0", blink, 0);
        pulse(0, 0, 1);
        cyc(1); chk("t6_ring_edit", bus, 24'h071E00);
        chk("t6_blink_lo", blink, 0);
        cyc(2); chk("t6_blink_hi", blink, 1);
        chk("t6_tgt1", set_tgt, 1);
        @(negedge clk1000);
        rst = 0;
        #1;
        chk("t6_rst_bus", bus, 0);
        chk("t6_rst_tgt", set_tgt, 0);
        chk("t6_rst_fld", field, 0);
        chk("t6_rst_blink", blink, 0);
        chk("t6_rst_load", set_load, 0);
        chk("t6_rst_val", set_val, 0);
        alarm_ring = 0;
        cyc(2);
        rst = 1;
        cyc(2);
        chk("t6_post_bus", bus, 24'h0C1E2D);
        chk("t6_noload", loads - loads0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
